// File: rtl/simon_round_engine.sv
// Simon128/256 encryption round engine: fetches NUM_ROUNDS subkeys from an external
// key memory and applies one round per returned subkey.
module simon_round_engine #(
  parameter int NUM_ROUNDS = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_compute_start,
  input  logic         key_mem_full,
  output logic         key_rd_en,
  output logic [8:0]   key_addr,
  input  logic [63:0]  key_data,
  input  logic         key_data_vld,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         keys_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] ROUNDS_M1 = 7'(NUM_ROUNDS - 1);

  state_t      state, state_nxt;
  logic [63:0] x, y, x_rnd;
  logic [6:0]  rd_cnt, vld_cnt;
  logic        in_xfer, out_xfer, round_vld, last_vld, abort;

  assign in_ready  = (state == IDLE) && keys_ready;
  assign out_valid = (state == DONE);
  assign key_rd_en = (state == RUN) && (rd_cnt <= ROUNDS_M1);
  assign key_addr  = {2'b00, rd_cnt};

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // Returns outside RUN are stale (left over from an aborted block) and are dropped.
  assign round_vld = (state == RUN) && key_data_vld;
  assign last_vld  = round_vld && (vld_cnt == ROUNDS_M1);
  assign abort     = key_compute_start && (state != IDLE);

  // One Simon round: f(x) = (rol1 & rol8) ^ rol2, pure bitwise on 64-bit words.
  assign x_rnd = y ^ (({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]})
                   ^ key_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment first guarantees every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_xfer) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_vld) state_nxt = DONE;
      end
      DONE: begin
        if (abort)         state_nxt = IDLE;
        else if (out_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear beats set so a restarted key schedule never leaves stale keys marked usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_ready <= 1'b0;
    end else if (key_compute_start) begin
      keys_ready <= 1'b0;
    end else if (key_mem_full) begin
      keys_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      rd_cnt   <= '0;
      vld_cnt  <= '0;
      out_data <= '0;
    end else if (in_xfer) begin
      x       <= in_data[127:64];
      y       <= in_data[63:0];
      rd_cnt  <= '0;
      vld_cnt <= '0;
    end else if (abort) begin
      rd_cnt  <= '0;
      vld_cnt <= '0;
    end else if (state == RUN) begin
      if (key_rd_en) rd_cnt <= rd_cnt + 7'd1;
      if (round_vld) begin
        x       <= x_rnd;
        y       <= x;
        vld_cnt <= vld_cnt + 7'd1;
        if (last_vld) out_data <= {x_rnd, x};
      end
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// Self-checking bench for simon_round_engine: models a 2-cycle key memory, keeps a
// scoreboard of expected ciphertexts from a reference Simon128/256 model.
module tb_simon_round_engine;

  localparam int NR = 72;
  localparam logic [127:0] KAT_PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] KAT_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_compute_start = 1'b0;
  logic         key_mem_full = 1'b0;
  logic         key_rd_en;
  logic [8:0]   key_addr;
  logic [63:0]  key_data;
  logic         key_data_vld;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         keys_ready;

  simon_round_engine #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst),
    .key_compute_start(key_compute_start), .key_mem_full(key_mem_full),
    .key_rd_en(key_rd_en), .key_addr(key_addr),
    .key_data(key_data), .key_data_vld(key_data_vld),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .keys_ready(keys_ready)
  );

  always #5 clk = ~clk;

  // Subkeys and a two-stage pipelined key memory.
  logic [63:0] rk [NR];
  logic       p1_vld = 1'b0, p2_vld = 1'b0;
  logic [8:0] p1_addr = '0, p2_addr = '0;
  always @(posedge clk) begin
    p1_vld  <= key_rd_en;
    p1_addr <= key_addr;
    p2_vld  <= p1_vld;
    p2_addr <= p1_addr;
  end
  assign key_data_vld = p2_vld;
  assign key_data     = rk[p2_addr[6:0]];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  task automatic build_keys();
    logic [63:0] z;
    logic [63:0] tmp;
    z = 64'h3DC94C3A046D678B;
    rk[0] = 64'h0706050403020100;
    rk[1] = 64'h0f0e0d0c0b0a0908;
    rk[2] = 64'h1716151413121110;
    rk[3] = 64'h1f1e1d1c1b1a1918;
    for (int i = 4; i < NR; i++) begin
      tmp = ror(rk[i-1], 3) ^ rk[i-3];
      tmp = tmp ^ ror(tmp, 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {63'd0, z[(i-4) % 62]} ^ 64'd3;
    end
  endtask

  function automatic logic [127:0] simon_enc(input logic [127:0] pt);
    logic [63:0] a, b, t;
    a = pt[127:64];
    b = pt[63:0];
    for (int i = 0; i < NR; i++) begin
      t = a;
      a = b ^ ((rol(a, 1) & rol(a, 8)) ^ rol(a, 2)) ^ rk[i];
      b = t;
    end
    return {a, b};
  endfunction

  // Scoreboard and monitor state.
  logic [127:0] exp_q [$];
  logic [127:0] last_out = '0;
  int  cyc = 0, xfer_cyc = 0, ov_cyc = 0, n_out = 0;
  int  viol_out = 0, viol_req = 0;
  bit  forbid_out = 1'b0, no_req = 1'b0, ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !ov_prev) ov_cyc = cyc + 1;
    ov_prev = out_valid;
    if (forbid_out && out_valid) viol_out++;
    if (no_req && key_rd_en)     viol_req++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 128'(exp_q.size()), 128'd1);
      end else begin
        check("ciphertext", out_data, exp_q.pop_front());
      end
      last_out = out_data;
      n_out++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_keys_full();
    key_mem_full = 1'b1;
    tick(1);
    key_mem_full = 1'b0;
  endtask

  // Drives one block; returns just after its transfer edge.
  task automatic send(input logic [127:0] pt, input bit expect_out);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = pt;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 300) begin
        check("send_timeout", 128'(in_ready), 128'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xfer_cyc = cyc;
    if (expect_out) exp_q.push_back(simon_enc(pt));
  endtask

  task automatic wait_out(input string tag);
    int start, w;
    start = n_out;
    w = 0;
    while (n_out == start) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        check({tag, "_timeout"}, 128'(n_out - start), 128'd1);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, hold;
    int bp_viol, w;
    build_keys();

    // Reset values, asserted asynchronously before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_ctrl", 128'({in_ready, out_valid, key_rd_en, keys_ready, key_addr}), 128'd0);
    check("rst_data", out_data, 128'd0);
    tick(3);
    rst = 1'b0;

    // No keys yet: plaintext offered but never accepted, no key reads.
    no_req   = 1'b1;
    in_valid = 1'b1;
    in_data  = KAT_PT;
    tick(10);
    check("nokeys_in_ready", 128'(in_ready), 128'd0);
    check("nokeys_rd_en", 128'(viol_req), 128'd0);
    in_valid = 1'b0;
    no_req   = 1'b0;

    // Simultaneous set/clear of keys_ready: clear wins.
    key_mem_full      = 1'b1;
    key_compute_start = 1'b1;
    tick(1);
    key_mem_full      = 1'b0;
    key_compute_start = 1'b0;
    check("kr_collide", 128'({keys_ready, in_ready}), 128'd0);
    pulse_keys_full();
    check("kr_set", 128'({keys_ready, in_ready}), 128'd3);

    // Known answer with latency.
    out_ready = 1'b1;
    send(KAT_PT, 1'b1);
    wait_out("kat");
    check("kat_latency", 128'(ov_cyc - xfer_cyc), 128'd75);
    check("kat_ct", last_out, KAT_CT);

    // Backpressure: output held for 20 cycles, nothing else moves.
    out_ready = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, 1'b1);
    w = 0;
    while (!out_valid && w < 300) begin
      tick(1);
      w++;
    end
    check("bp_valid", 128'(out_valid), 128'd1);
    hold = out_data;
    bp_viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== hold || in_ready || key_rd_en || !out_valid) bp_viol++;
    end
    check("bp_hold", 128'(bp_viol), 128'd0);
    @(posedge clk);
    #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pt;
    tick(1);
    @(negedge clk);
    check("bp_next_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xfer_cyc = cyc;
    exp_q.push_back(simon_enc(pt));
    wait_out("bp_next");
    check("bp_next_latency", 128'(ov_cyc - xfer_cyc), 128'd75);

    // A few random blocks.
    for (int i = 0; i < 3; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_out("rand");
      check("rand_latency", 128'(ov_cyc - xfer_cyc), 128'd75);
    end

    // Abort mid-RUN: block discarded, stale returns ignored, rerun correct.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    tick(30);
    key_compute_start = 1'b1;
    tick(1);
    key_compute_start = 1'b0;
    forbid_out = 1'b1;
    check("abort_kr", 128'({keys_ready, in_ready, key_rd_en}), 128'd0);
    tick(100);
    check("abort_no_out", 128'(viol_out), 128'd0);
    check("abort_kr_held", 128'(keys_ready), 128'd0);
    forbid_out = 1'b0;
    pulse_keys_full();
    send(KAT_PT, 1'b1);
    wait_out("abort_rerun");
    check("abort_rerun_ct", last_out, KAT_CT);

    // Asynchronous reset between edges mid-RUN.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    tick(20);
    #3 rst = 1'b1;
    #1;
    check("arst_ctrl", 128'({in_ready, out_valid, key_rd_en, keys_ready, key_addr}), 128'd0);
    check("arst_data", out_data, 128'd0);
    forbid_out = 1'b1;
    tick(5);
    check("arst_held", 128'({in_ready, out_valid, key_rd_en, keys_ready, key_addr, out_data}),
          128'd0);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = KAT_PT;
    tick(100);
    check("arst_no_accept", 128'({in_ready, keys_ready}), 128'd0);
    check("arst_no_out", 128'(viol_out), 128'd0);
    in_valid   = 1'b0;
    forbid_out = 1'b0;
    pulse_keys_full();
    send(KAT_PT, 1'b1);
    wait_out("arst_rerun");
    check("arst_rerun_ct", last_out, KAT_CT);

    check("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
